// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding, widths and PC offsets.
package fetch_pkg;

  localparam int INSTR_W = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned PC_STEP     = 4;
  localparam int unsigned PC_READ_OFS = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection (sequential or redirect, word aligned) and the ARM read-PC (pc + 8).
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              pcsrc,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc_plus8
);

  logic [ADDR_W-1:0] target_aligned;

  // Low target bits are silently cleared; a misaligned redirect is never faulted.
  assign target_aligned = branch_target & ~ADDR_W'(3);

  assign pc_next  = pcsrc ? target_aligned : pc + ADDR_W'(PC_STEP);
  assign pc_plus8 = pc + ADDR_W'(PC_READ_OFS);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: req/ack reads from instruction memory, valid/ready presentation
// to the consumer, and PC redirect on accepted branches.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus8,
  input  logic               pcsrc,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [31:0]        fetch_count
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next_w;
  logic [ADDR_W-1:0] fetch_pc_plus8_w;

  // While in S_HOLD the fetch PC still equals the presented pc, so one adder pair
  // serves both the ack-time pc_plus8 capture and the ready-time next-PC update.
  fetch_pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc            (fetch_pc),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .pc_next       (fetch_pc_next_w),
    .pc_plus8      (fetch_pc_plus8_w)
  );

  // NOTE: all state here updates with non-blocking assignments so every register
  // samples pre-edge values; blocking assignments would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc          <= RESET_PC;
      pc_plus8    <= RESET_PC + ADDR_W'(PC_READ_OFS);
      fetch_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_REQ;
          imem_req  <= 1'b1;
          imem_addr <= fetch_pc;
        end
        S_REQ: begin
          if (imem_ack) begin
            state       <= S_HOLD;
            imem_req    <= 1'b0;
            instr       <= imem_rdata;
            pc          <= fetch_pc;
            pc_plus8    <= fetch_pc_plus8_w;
            instr_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            state       <= S_REQ;
            fetch_pc    <= fetch_pc_next_w;
            imem_req    <= 1'b1;
            imem_addr   <= fetch_pc_next_w;
            instr_valid <= 1'b0;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        // Unused encoding: recover by restarting the fetch handshake.
        default: begin
          state       <= S_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: sequential fetch, redirect, memory
// wait states, consumer back-pressure, address wrap and reset mid-request.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic [31:0] fetch_count;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic        w_ready;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus8;
  logic        w_pcsrc;
  logic [31:0] w_target;
  logic [31:0] w_count;

  int checks   = 0;
  int failures = 0;

  // Instruction memory contents: each word is a tag XOR its address.
  assign imem_rdata = 32'hA500_0000 ^ imem_addr;

  instr_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .pc            (pc),
    .pc_plus8      (pc_plus8),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .fetch_count   (fetch_count)
  );

  instr_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) u_wrap (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (w_ack),
    .imem_rdata    (w_rdata),
    .instr_valid   (w_valid),
    .instr         (w_instr),
    .instr_ready   (w_ready),
    .pc            (w_pc),
    .pc_plus8      (w_pc_plus8),
    .pcsrc         (w_pcsrc),
    .branch_target (w_target),
    .fetch_count   (w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    imem_ack      = 1'b0;
    instr_ready   = 1'b0;
    pcsrc         = 1'b0;
    branch_target = 32'h0;
    w_ack         = 1'b1;
    w_ready       = 1'b0;
    w_rdata       = 32'h0;
    w_pcsrc       = 1'b0;
    w_target      = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_req",      {31'b0, imem_req},    32'h0);
    check("rst_addr",     imem_addr,            32'h0);
    check("rst_valid",    {31'b0, instr_valid}, 32'h0);
    check("rst_instr",    instr,                32'h0);
    check("rst_pc",       pc,                   32'h0);
    check("rst_pc_plus8", pc_plus8,             32'h8);
    check("rst_count",    fetch_count,          32'h0);
    check("rst_w_addr",   w_addr,               32'hFFFF_FFFC);
    check("rst_w_plus8",  w_pc_plus8,           32'h0000_0004);

    // Zero-wait memory, consumer always ready: one instruction every two cycles
    reset       = 1'b0;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("seq_req",    {31'b0, imem_req},    32'h1);
      check("seq_addr",   imem_addr,            32'(i * 4));
      check("seq_nvalid", {31'b0, instr_valid}, 32'h0);
      check("seq_count",  fetch_count,          32'(i));
      step();
      check("seq_valid",  {31'b0, instr_valid}, 32'h1);
      check("seq_pc",     pc,                   32'(i * 4));
      check("seq_plus8",  pc_plus8,             32'(i * 4 + 8));
      check("seq_instr",  instr,                32'hA500_0000 | 32'(i * 4));
      step();
    end
    check("seq_count4", fetch_count, 32'd4);

    // pcsrc during S_REQ must not redirect
    imem_ack      = 1'b0;
    pcsrc         = 1'b1;
    branch_target = 32'h0000_0200;
    step();
    check("req_pcsrc_addr", imem_addr,         32'h0000_0010);
    check("req_pcsrc_req",  {31'b0, imem_req}, 32'h1);
    pcsrc    = 1'b0;
    imem_ack = 1'b1;
    step();
    check("br_valid", {31'b0, instr_valid}, 32'h1);
    check("br_pc",    pc,                   32'h0000_0010);
    check("br_plus8", pc_plus8,             32'h0000_0018);
    check("br_instr", instr,                32'hA500_0010);

    // Redirect on acceptance with a misaligned target
    pcsrc         = 1'b1;
    branch_target = 32'h0000_0103;
    step();
    check("br_addr",  imem_addr,         32'h0000_0100);
    check("br_req",   {31'b0, imem_req}, 32'h1);
    check("br_count", fetch_count,       32'd5);
    pcsrc         = 1'b0;
    branch_target = 32'h0;

    // Memory ack delayed by three cycles
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait_req",    {31'b0, imem_req},    32'h1);
      check("wait_addr",   imem_addr,            32'h0000_0100);
      check("wait_nvalid", {31'b0, instr_valid}, 32'h0);
      step();
    end
    check("wait_req_last",  {31'b0, imem_req}, 32'h1);
    check("wait_addr_last", imem_addr,         32'h0000_0100);
    imem_ack    = 1'b1;
    instr_ready = 1'b0;
    step();
    check("ack_valid", {31'b0, instr_valid}, 32'h1);
    check("ack_instr", instr,                32'hA500_0100);
    check("ack_pc",    pc,                   32'h0000_0100);
    check("ack_req",   {31'b0, imem_req},    32'h0);

    // Consumer back-pressure: presented instruction held, no new request
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {31'b0, instr_valid}, 32'h1);
      check("hold_instr", instr,                32'hA500_0100);
      check("hold_pc",    pc,                   32'h0000_0100);
      check("hold_plus8", pc_plus8,             32'h0000_0108);
      check("hold_req",   {31'b0, imem_req},    32'h0);
    end
    instr_ready = 1'b1;
    step();
    check("rel_req",   {31'b0, imem_req},    32'h1);
    check("rel_addr",  imem_addr,            32'h0000_0104);
    check("rel_count", fetch_count,          32'd6);
    check("rel_valid", {31'b0, instr_valid}, 32'h0);
    imem_ack    = 1'b0;
    instr_ready = 1'b0;

    // Address wrap on the high-RESET_PC instance
    check("wrap_valid", {31'b0, w_valid}, 32'h1);
    check("wrap_pc",    w_pc,             32'hFFFF_FFFC);
    check("wrap_plus8", w_pc_plus8,       32'h0000_0004);
    w_ready = 1'b1;
    step();
    check("wrap_addr",  w_addr,           32'h0000_0000);
    check("wrap_req",   {31'b0, w_req},   32'h1);
    check("wrap_count", w_count,          32'd1);
    w_ready = 1'b0;

    // Reset asserted mid-request takes effect without a clock edge
    #2 reset = 1'b1;
    #1;
    check("midrst_req",   {31'b0, imem_req},    32'h0);
    check("midrst_addr",  imem_addr,            32'h0);
    check("midrst_valid", {31'b0, instr_valid}, 32'h0);
    check("midrst_pc",    pc,                   32'h0);
    check("midrst_plus8", pc_plus8,             32'h8);
    check("midrst_count", fetch_count,          32'h0);
    @(negedge clk);
    reset    = 1'b0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("stray_req",    {31'b0, imem_req},    32'h1);
    check("stray_addr",   imem_addr,            32'h0);
    check("stray_valid",  {31'b0, instr_valid}, 32'h0);
    step();
    check("stray_valid2", {31'b0, instr_valid}, 32'h0);
    check("stray_req2",   {31'b0, imem_req},    32'h1);
    imem_ack = 1'b1;
    step();
    check("post_valid", {31'b0, instr_valid}, 32'h1);
    check("post_pc",    pc,                   32'h0);
    check("post_instr", instr,                32'hA500_0000);
    check("post_count", fetch_count,          32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
